// File: rtl/vga_frame_capture.sv
// rtl/vga_frame_capture.sv - VGA sync recovery, frame lock and active-area pixel stream capture
// Measures line/frame totals from the sync edges, locks on stable timing, and streams active pixels through a small FIFO.
module vga_frame_capture #(
  parameter int   H_ACTIVE   = 640,
  parameter int   V_ACTIVE   = 480,
  parameter int   H_START    = 144,
  parameter int   V_START    = 35,
  parameter logic SYNC_POL   = 1'b0,
  parameter int   FIFO_DEPTH = 4,
  parameter int   CNT_W      = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             hsync,
  input  logic             vsync,
  input  logic [3:0]       R,
  input  logic [3:0]       G,
  input  logic [3:0]       B,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic [11:0]      pix_rgb,
  output logic             pix_sof,
  output logic             pix_eol,
  output logic             frame_done,
  output logic [15:0]      frame_cnt,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] v_total,
  output logic             locked,
  output logic             overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] H_LO    = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] H_HI    = CNT_W'(H_START + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_LO    = CNT_W'(V_START);
  localparam logic [CNT_W-1:0] V_HI    = CNT_W'(V_START + V_ACTIVE);
  localparam logic [CNT_W-1:0] X_LAST  = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(V_ACTIVE - 1);

  typedef enum logic [1:0] {WAIT_VS, WAIT_LOCK, LOCKED} state_t;

  typedef struct packed {
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic [11:0]      rgb;
    logic             sof;
    logic             eol;
  } entry_t;

  logic             hs_q, vs_q, hs_prev_q, vs_prev_q;
  logic [11:0]      rgb_q;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [CNT_W-1:0] h_total_q, h_total_d, v_total_q, v_total_d;
  state_t           state_q, state_d;
  logic             overflow_q, frame_done_q;
  logic [15:0]      frame_cnt_q;
  entry_t           mem_q [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;

  logic             hs_on, vs_on, hs_edge, vs_edge, timing_ok;
  logic             active, push, drop, pop, full, last_pix;
  logic [CNT_W-1:0] x_c, y_c;
  entry_t           wr_entry, head;

  assign hs_on   = (hs_q == SYNC_POL);
  assign vs_on   = (vs_q == SYNC_POL);
  assign hs_edge = hs_on && !hs_prev_q;
  assign vs_edge = vs_on && !vs_prev_q;

  always_comb begin
    h_cnt_d   = h_cnt_q;
    h_total_d = h_total_q;
    v_cnt_d   = v_cnt_q;
    v_total_d = v_total_q;
    if (hs_edge) begin
      h_cnt_d   = '0;
      h_total_d = h_cnt_q + 1'b1;
    end else if (h_cnt_q != CNT_MAX) begin
      h_cnt_d = h_cnt_q + 1'b1;
    end
    if (vs_edge) begin
      v_cnt_d   = '0;
      v_total_d = v_cnt_q + 1'b1;
    end else if (hs_edge && v_cnt_q != CNT_MAX) begin
      v_cnt_d = v_cnt_q + 1'b1;
    end
  end

  // Lock decisions use the totals measured on this very edge.
  always_comb begin
    state_d   = state_q;
    timing_ok = (v_total_d >= V_HI) && (h_total_d >= H_HI);
    if (vs_edge) begin
      case (state_q)
        WAIT_VS:   state_d = WAIT_LOCK;
        WAIT_LOCK: if (timing_ok) state_d = LOCKED;
        LOCKED:    if (!timing_ok || v_total_d != v_total_q) state_d = WAIT_LOCK;
        default:   state_d = WAIT_VS;
      endcase
    end
  end

  assign full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop  = pix_valid && pix_ready;

  always_comb begin
    x_c          = h_cnt_q - H_LO;
    y_c          = v_cnt_q - V_LO;
    active       = en && (state_q == LOCKED) && (h_cnt_q >= H_LO) && (h_cnt_q < H_HI)
                   && (v_cnt_q >= V_LO) && (v_cnt_q < V_HI);
    wr_entry.x   = x_c;
    wr_entry.y   = y_c;
    wr_entry.rgb = rgb_q;
    wr_entry.sof = (x_c == '0) && (y_c == '0);
    wr_entry.eol = (x_c == X_LAST);
    push         = active && (!full || pop);
    drop         = active && full && !pop;
    last_pix     = active && (x_c == X_LAST) && (y_c == Y_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
  end

  // Sync registers reset to the deasserted level so reset itself never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q         <= ~SYNC_POL;
      vs_q         <= ~SYNC_POL;
      hs_prev_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      rgb_q        <= '0;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      h_total_q    <= '0;
      v_total_q    <= '0;
      state_q      <= WAIT_VS;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      frame_done_q <= last_pix;
      if (pop)      rd_ptr_q    <= rd_ptr_q + 1'b1;
      if (push)     wr_ptr_q    <= wr_ptr_q + 1'b1;
      if (drop)     overflow_q  <= 1'b1;
      if (last_pix) frame_cnt_q <= frame_cnt_q + 1'b1;
      if (en) begin
        hs_q      <= hsync;
        vs_q      <= vsync;
        rgb_q     <= {R, G, B};
        hs_prev_q <= hs_on;
        vs_prev_q <= vs_on;
        h_cnt_q   <= h_cnt_d;
        v_cnt_q   <= v_cnt_d;
        h_total_q <= h_total_d;
        v_total_q <= v_total_d;
        state_q   <= state_d;
      end
    end
  end

  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign pix_valid  = (wr_ptr_q != rd_ptr_q);
  assign pix_x      = pix_valid ? head.x   : '0;
  assign pix_y      = pix_valid ? head.y   : '0;
  assign pix_rgb    = pix_valid ? head.rgb : '0;
  assign pix_sof    = pix_valid && head.sof;
  assign pix_eol    = pix_valid && head.eol;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign h_total    = h_total_q;
  assign v_total    = v_total_q;
  assign locked     = (state_q == LOCKED);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_vga_frame_capture.sv
// tb/tb_vga_frame_capture.sv - scoreboard bench for vga_frame_capture on a reduced 20x8 raster
// A source model drives sync/RGB; expected pixels are queued at drive time and matched by a separate monitor.
module tb_vga_frame_capture;
  localparam int HA  = 12;
  localparam int VA  = 4;
  localparam int HST = 4;
  localparam int VST = 2;
  localparam int HT  = 20;
  localparam int HS  = 2;
  localparam int VS  = 1;
  localparam int CW  = 10;

  logic          clk = 1'b0;
  logic          rst, en, hsync, vsync, pix_ready;
  logic [3:0]    R, G, B;
  logic          pix_valid, pix_sof, pix_eol, frame_done, locked, overflow;
  logic [CW-1:0] pix_x, pix_y, h_total, v_total;
  logic [11:0]   pix_rgb;
  logic [15:0]   frame_cnt;

  vga_frame_capture #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_START(HST), .V_START(VST),
    .SYNC_POL(1'b0), .FIFO_DEPTH(4), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .hsync(hsync), .vsync(vsync),
    .R(R), .G(G), .B(B),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .pix_sof(pix_sof), .pix_eol(pix_eol),
    .frame_done(frame_done), .frame_cnt(frame_cnt),
    .h_total(h_total), .v_total(v_total),
    .locked(locked), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [33:0] d;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          hc, vc, last_key;
  int          out_cnt, sof_cnt, eol_cnt, fd_cnt;
  bit          cap_frame, mode_order, lat_chk, hold_v;
  logic [34:0] held;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cycle);
    end
  endtask

  function automatic logic [33:0] pack_out();
    return {pix_x, pix_y, pix_rgb, pix_sof, pix_eol};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (frame_done) fd_cnt++;
      if (hold_v) check("hold_stable", {pix_valid, pack_out()}, held);
      hold_v = pix_valid && !pix_ready;
      held   = {1'b1, pack_out()};
      if (pix_valid && pix_ready) begin
        out_cnt++;
        if (pix_sof) sof_cnt++;
        if (pix_eol) eol_cnt++;
        if (!mode_order) begin
          check("sb_nonempty_on_output", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("pixel", pack_out(), e.d);
            if (lat_chk) check("latency", cycle - e.cyc, 2);
          end
        end else begin
          int key;
          key = int'(pix_y) * HA + int'(pix_x);
          check("order", key > last_key, 1);
          last_key = key;
          check("rgb_eq_x", pix_rgb, {2'b00, pix_x});
          check("sof_flag", pix_sof, (pix_x == 0) && (pix_y == 0));
          check("eol_flag", pix_eol, pix_x == CW'(HA - 1));
          check("xy_range", (pix_x < HA) && (pix_y < VA), 1);
        end
      end
    end
  end

  // The pixel at source column hc reaches the DUT pipeline with h_cnt = hc-1, so x = hc-HST-1.
  task automatic drive_cycle(input bit toggle);
    logic [11:0] v;
    exp_t        e;
    logic [9:0]  x, y;
    v = 12'(hc - HST - 1);
    hsync = (hc < HS) ? 1'b0 : 1'b1;
    vsync = (vc < VS) ? 1'b0 : 1'b1;
    {R, G, B} = v;
    if (toggle) pix_ready = ~pix_ready;
    if (en && cap_frame && hc >= HST + 1 && hc <= HST + HA && vc >= VST && vc < VST + VA) begin
      x = 10'(hc - HST - 1);
      y = 10'(vc - VST);
      e.d   = {x, y, v, (x == 0) && (y == 0), x == 10'(HA - 1)};
      e.cyc = cycle;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (en) begin
      hc++;
      if (hc == HT) begin
        hc = 0;
        vc++;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pix_valid"}, pix_valid, 0);
    check({tag, "_pix_data"}, pack_out(), 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
    check({tag, "_h_total"}, h_total, 0);
    check({tag, "_v_total"}, v_total, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_overflow"}, overflow, 0);
  endtask

  task automatic run_frame(input int lines, input bit cap, input bit pause, input bit do_rst,
                           input bit toggle, input bit ovf_chk);
    bit done_pause, done_rst;
    done_pause = 1'b0;
    done_rst   = 1'b0;
    cap_frame  = cap;
    out_cnt    = 0;
    sof_cnt    = 0;
    eol_cnt    = 0;
    fd_cnt     = 0;
    last_key   = -1;
    hc         = 0;
    vc         = 0;
    while (vc < lines) begin
      if (pause && !done_pause && vc == 3 && hc == 9) begin
        en        = 1'b0;
        pix_ready = 1'b0;
        repeat (20) drive_cycle(1'b0);
        check("pause_hold_valid", pix_valid, 1);
        check("pause_hold_x", pix_x, 2);
        pix_ready = 1'b1;
        repeat (80) drive_cycle(1'b0);
        check("pause_drained", pix_valid, 0);
        en         = 1'b1;
        done_pause = 1'b1;
      end else if (do_rst && !done_rst && vc == 3 && hc == 2) begin
        check("sb_empty_at_rst", sb.size(), 0);
        cap_frame = 1'b0;
        rst = 1'b1;
        drive_cycle(1'b0);
        rst = 1'b0;
        check_reset_outputs("midrst");
        done_rst = 1'b1;
      end else begin
        if (ovf_chk && vc == VST + 1 && hc == 0) check("overflow_first_line", overflow, 1);
        drive_cycle(toggle);
      end
    end
  endtask

  task automatic expect_full_frame(input string tag, input int fcnt);
    check({tag, "_locked"}, locked, 1);
    check({tag, "_pixels"}, out_cnt, HA * VA);
    check({tag, "_sof"}, sof_cnt, 1);
    check({tag, "_eol"}, eol_cnt, VA);
    check({tag, "_frame_done"}, fd_cnt, 1);
    check({tag, "_frame_cnt"}, frame_cnt, fcnt);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; pix_ready = 1'b1; hsync = 1'b1; vsync = 1'b1;
    {R, G, B} = 12'h0;
    cap_frame = 1'b0; mode_order = 1'b0; lat_chk = 1'b0; hold_v = 1'b0;
    hc = 0; vc = 0; last_key = -1;
    out_cnt = 0; sof_cnt = 0; eol_cnt = 0; fd_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("reset");

    // Lock acquisition and first captured frame.
    run_frame(8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("f0_locked", locked, 0);
    lat_chk = 1'b1;
    run_frame(8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    lat_chk = 1'b0;
    expect_full_frame("f1", 1);
    check("f1_h_total", h_total, HT);
    check("f1_v_total", v_total, 8);
    check("f1_overflow", overflow, 0);

    // Back-pressure: drops, sticky overflow, ordering.
    mode_order = 1'b1;
    run_frame(8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    pix_ready  = 1'b1;
    mode_order = 1'b0;
    check("f2_overflow", overflow, 1);
    check("f2_dropped", out_cnt < HA * VA, 1);
    check("f2_frame_done", fd_cnt, 1);
    check("f2_frame_cnt", frame_cnt, 2);

    // Frame length change: drop lock, then relock.
    run_frame(9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_full_frame("f3", 3);
    run_frame(9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("f4_locked", locked, 0);
    check("f4_v_total", v_total, 9);
    check("f4_pixels", out_cnt, 0);
    check("f4_frame_cnt", frame_cnt, 3);
    run_frame(9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_full_frame("f5", 4);

    // Capture-side freeze mid-line.
    run_frame(9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_full_frame("f6", 5);

    // Mid-frame reset, then two vsync edges to relock.
    run_frame(9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("f7_locked", locked, 0);
    check("f7_frame_cnt", frame_cnt, 0);
    run_frame(9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("f8_locked", locked, 0);
    check("f8_pixels", out_cnt, 0);
    run_frame(9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_full_frame("f9", 1);
    check("f9_h_total", h_total, HT);

    // Frames too short to ever lock.
    rst = 1'b1; hsync = 1'b1; vsync = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int f = 0; f < 4; f++) begin
      run_frame(5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("short_locked", locked, 0);
      check("short_pixels", out_cnt, 0);
    end
    check("short_v_total", v_total, 5);
    check("short_frame_cnt", frame_cnt, 0);
    check("short_pix_valid", pix_valid, 0);
    check("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_frame_capture.md
Name: vga_frame_capture

Overview:
- Downstream consumer of the debug-screen VGA output (hsync, vsync, 4-bit R/G/B).
- Recovers line/frame timing from the sync pulses and measures h_total/v_total.
- Locks onto a stable frame and emits the active-area pixels as a valid/ready stream tagged with x, y, start-of-frame and end-of-line.
- Feeds the in-system frame grabber and the image-dump path. One clk cycle = one pixel.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- H_START, 144, h_cnt of first active pixel (sync + back porch)
- V_START, 35, v_cnt of first active line
- SYNC_POL, 0, sync asserted level (0 = active-low)
- FIFO_DEPTH, 4, output FIFO entries (power of 2, ≥2)
- CNT_W, 10, width of h/v counters, x/y and totals

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- en  in  1  capture-side clock enable
- hsync  in  1  horizontal sync from VGA core
- vsync  in  1  vertical sync from VGA core
- R  in  4  red
- G  in  4  green
- B  in  4  blue
- pix_valid  out  1  stream data valid
- pix_ready  in  1  downstream accept
- pix_x  out  CNT_W  active-area column
- pix_y  out  CNT_W  active-area row
- pix_rgb  out  12  {R,G,B}
- pix_sof  out  1  pixel is x=0,y=0
- pix_eol  out  1  pixel is x=H_ACTIVE-1
- frame_done  out  1  one-cycle pulse, last active pixel of a frame processed
- frame_cnt  out  16  captured-frame counter, wraps
- h_total  out  CNT_W  last measured line length (cycles)
- v_total  out  CNT_W  last measured frame length (lines)
- locked  out  1  timing lock
- overflow  out  1  sticky FIFO-full drop flag

Behaviour:
- Reset: every output 0, FIFO emptied, counters 0, FSM = WAIT_VS. Reset applied mid-frame takes effect on the next edge with no partial output.
- en=0 freezes the input registers, counters, FSM and FIFO writes. The FIFO read side (pix_valid/pix_ready) keeps operating.
- Input stage: hsync, vsync, RGB registered once. Sync is asserted when registered level == SYNC_POL. Edge = asserted now and not asserted on the previous enabled cycle.
- h_cnt:
  - On hsync edge: h_cnt <= 0 and h_total <= h_cnt+1.
  - Otherwise h_cnt increments, saturating at 2^CNT_W-1.
- v_cnt:
  - Increments on each hsync edge.
  - On vsync edge: v_cnt <= 0 and v_total <= v_cnt+1.
  - vsync edge takes priority when it coincides with an hsync edge.
- FSM (evaluated on vsync edges only):
  - WAIT_VS -> WAIT_LOCK.
  - WAIT_LOCK -> LOCKED if new v_total ≥ V_START+V_ACTIVE and h_total ≥ H_START+H_ACTIVE; otherwise stays.
  - LOCKED -> WAIT_LOCK if that check fails or new v_total ≠ previous v_total.
- locked = (state==LOCKED), registered.
- Capture: in LOCKED, a pixel is active when H_START ≤ h_cnt < H_START+H_ACTIVE and V_START ≤ v_cnt < V_START+V_ACTIVE. Its entry is:
  - x = h_cnt-H_START
  - y = v_cnt-V_START
  - rgb = registered {R,G,B}
  - sof = (x==0 && y==0)
  - eol = (x==H_ACTIVE-1)
- Active pixel with FIFO not full: written. FIFO full: pixel dropped and overflow <= 1 (cleared only by rst). A simultaneous pop frees space in the same cycle, so no drop occurs.
- Last active pixel (written or dropped): frame_done pulses one cycle and frame_cnt increments.
- Stream: pix_valid = FIFO not empty; pop on pix_valid && pix_ready. While pix_valid && !pix_ready, all pix_* outputs hold stable. Order is preserved; no pixel is duplicated.
- Latency: pixel presented on R/G/B at cycle n appears on pix_* at cycle n+2 when the FIFO is empty and en=1.

Test Plan:
1. Reset, then 800x525 timing (hsync 96, vsync 2 lines, active-low) with pixel value = x[11:0], pix_ready=1 -> locked=1 after second vsync edge; h_total=800, v_total=525; next frame yields exactly 307200 pixels, single pix_sof at (0,0), 480 pix_eol, rgb == x, frame_done once, frame_cnt=1.
2. Same stream with pix_ready high every other cycle -> overflow=1 during the first line; emitted pixels strictly increasing in (y,x) with no duplicates; outputs stable whenever valid && !ready.
3. Locked, then switch to 628-line frames -> locked falls at the first vsync edge with v_total=628; zero pixels during the following frame; relock one frame later, capture resumes.
4. en=0 for 100 cycles mid-active-line -> h_cnt, v_cnt, FIFO contents frozen; queued pixels still drain; capture resumes at the same x when en=1.
5. Assert rst mid-frame for one cycle -> all outputs 0 next cycle; no pixel emitted before locked re-asserts two vsync edges later.
6. 400-line frames (v_total=400 < 515) -> locked never asserts, pix_valid stays 0, frame_cnt stays 0.
